alu_mp_sequencer: RTL and testbench

- Multi-precision initiator for the 64-bit word ALU.
- Accepts one wide command (NWORDS x WORD_W operands plus opcode) over a valid/ready handshake.
- Issues the command to the ALU one word per cycle, LSW first, chaining carry/borrow between words.
- Collects the wide result, carry-out and zero flag, and returns them over a valid/ready response handshake.
- Sits between the datapath control and the combinational ALU; the ALU is instantiated beside it by the integrator.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mp_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_mp_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: opcodes,
// opcode classification helpers and the sequencer FSM state type.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_NAND = 4'b1101;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True for every opcode the word ALU implements.
   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NAND, OP_NOR: legal = 1'b1;
         default:                                        legal = 1'b0;
      endcase
      return legal;
   endfunction

   // True for opcodes that consume and produce a carry/borrow.
   function automatic logic is_arith_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_mp_sequencer.sv
// Multi-precision initiator for a combinational word ALU. A wide command is
// latched, fed to the ALU one word per cycle (LSW first) with the carry/borrow
// chained through a register, and the wide result is returned over a
// valid/ready response handshake.
module alu_mp_sequencer
   import alu_pkg::*;
#(
   parameter int WORD_W = 64,
   parameter int NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [WORD_W*NWORDS-1:0] cmd_a,
   input  logic [WORD_W*NWORDS-1:0] cmd_b,
   input  logic                     cmd_cin,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WORD_W*NWORDS-1:0] rsp_result,
   output logic                     rsp_cout,
   output logic                     rsp_zero,
   output logic                     rsp_err,
   output logic [WORD_W-1:0]        alu_a,
   output logic [WORD_W-1:0]        alu_b,
   output logic [3:0]               alu_op,
   output logic                     alu_cin,
   input  logic [WORD_W-1:0]        alu_result,
   input  logic                     alu_cout
);

   localparam int W     = WORD_W * NWORDS;
   localparam int IDX_W = $clog2(NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic [W-1:0]       a_reg, b_reg;
   logic [3:0]         op_reg;
   logic               cin_reg;
   logic               carry_reg;
   logic [W-1:0]       result_reg;

   logic               rsp_valid_reg;
   logic [W-1:0]       rsp_result_reg;
   logic               rsp_cout_reg;
   logic               rsp_zero_reg;
   logic               rsp_err_reg;

   logic [W-1:0]       result_next;
   logic               carry_next;
   logic               last_word;

   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_cout   = rsp_cout_reg;
   assign rsp_zero   = rsp_zero_reg;
   assign rsp_err    = rsp_err_reg;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic, handshake ready and the ALU drive (zero outside RUN).
   always_comb begin
      state_next = state_reg;
      cmd_ready  = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = 4'b0000;
      alu_cin    = 1'b0;
      last_word  = (idx_reg == LAST_IDX);
      case (state_reg)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_next = is_legal_op(cmd_op) ? ST_RUN : ST_RESP;
         end
         ST_RUN: begin
            alu_a  = a_reg[int'(idx_reg)*WORD_W +: WORD_W];
            alu_b  = b_reg[int'(idx_reg)*WORD_W +: WORD_W];
            alu_op = op_reg;
            // Logic ops never see a carry; arithmetic chains word to word.
            if (is_arith_op(op_reg))
               alu_cin = (idx_reg == '0) ? cin_reg : carry_reg;
            if (last_word)
               state_next = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_valid_reg && rsp_ready)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Result register with the current word merged in, plus the word's carry.
   always_comb begin
      result_next = result_reg;
      result_next[int'(idx_reg)*WORD_W +: WORD_W] = alu_result;
      carry_next  = is_arith_op(op_reg) ? alu_cout : 1'b0;
   end

   // Operand latch, word accumulation and the registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg        <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         op_reg         <= 4'b0000;
         cin_reg        <= 1'b0;
         carry_reg      <= 1'b0;
         result_reg     <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= '0;
         rsp_cout_reg   <= 1'b0;
         rsp_zero_reg   <= 1'b0;
         rsp_err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  a_reg      <= cmd_a;
                  b_reg      <= cmd_b;
                  op_reg     <= cmd_op;
                  cin_reg    <= cmd_cin;
                  carry_reg  <= 1'b0;
                  result_reg <= '0;
                  idx_reg    <= '0;
                  // An illegal command is answered without touching the ALU;
                  // its response is published one cycle later from RESP.
                  rsp_result_reg <= '0;
                  rsp_cout_reg   <= 1'b0;
                  rsp_zero_reg   <= 1'b0;
                  rsp_err_reg    <= !is_legal_op(cmd_op);
               end
            end
            ST_RUN: begin
               result_reg <= result_next;
               carry_reg  <= carry_next;
               idx_reg    <= last_word ? '0 : idx_reg + IDX_W'(1);
               if (last_word) begin
                  rsp_valid_reg  <= 1'b1;
                  rsp_result_reg <= result_next;
                  rsp_cout_reg   <= carry_next;
                  rsp_zero_reg   <= (result_next == '0) && !carry_next;
                  rsp_err_reg    <= 1'b0;
               end
            end
            ST_RESP: begin
               if (!rsp_valid_reg)
                  rsp_valid_reg <= 1'b1;
               else if (rsp_ready)
                  rsp_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer: a behavioural word ALU sits beside the DUT,
// directed commands push hand-computed responses into a scoreboard queue and
// an independent monitor pops and compares on every response handshake.
module tb_alu_mp_sequencer;

   localparam int WORD_W = 64;
   localparam int NWORDS = 4;
   localparam int W      = WORD_W * NWORDS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [3:0]        cmd_op = 4'b0000;
   logic [W-1:0]      cmd_a = '0;
   logic [W-1:0]      cmd_b = '0;
   logic              cmd_cin = 1'b0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [W-1:0]      rsp_result;
   logic              rsp_cout;
   logic              rsp_zero;
   logic              rsp_err;
   logic [WORD_W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]        alu_op;
   logic              alu_cin, alu_cout;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         zero;
      logic         err;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   alu_mp_sequencer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout)
   );

   // Behavioural 64-bit word ALU (the sibling instance in the real system).
   always_comb begin
      alu_result = '0;
      alu_cout   = 1'b0;
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {{WORD_W{1'b0}}, alu_cin};
         4'b0110: {alu_cout, alu_result} = {1'b0, alu_a} - {1'b0, alu_b} - {{WORD_W{1'b0}}, alu_cin};
         4'b1101: alu_result = ~(alu_a & alu_b);
         4'b1100: alu_result = ~(alu_a | alu_b);
         default: ;
      endcase
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Scoreboard monitor: compares every accepted response against the queue.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got result=%h err=%b expected no response", rsp_result, rsp_err);
         end else begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".result"}, rsp_result, e.res);
            chk({nm, ".cout"}, W'(rsp_cout), W'(e.cout));
            chk({nm, ".zero"}, W'(rsp_zero), W'(e.zero));
            chk({nm, ".err"}, W'(rsp_err), W'(e.err));
            $display("txn %s: result=%h cout=%b zero=%b err=%b", nm, rsp_result, rsp_cout, rsp_zero, rsp_err);
         end
      end
   end

   // Wait (bounded) until the DUT can take a command; inputs change at posedge+1.
   task automatic wait_ready(input string nm);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL %s.ready_timeout: cmd_ready=0 expected 1 within 20 cycles", nm);
      end
   endtask

   // Issue one command, check latency / ALU drive side conditions, and
   // optionally hold off the response for 'hold' cycles.
   task automatic run_cmd(input string nm, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] e_res, input logic e_cout, input logic e_zero,
                          input logic e_err, input int e_lat, input int hold,
                          input logic chk_cin0, input logic chk_op0);
      exp_t         e;
      int           lat;
      logic [W-1:0] snap_res;
      logic [2:0]   snap_flags;
      wait_ready(nm);
      rsp_ready = (hold == 0);
      e.res = e_res; e.cout = e_cout; e.zero = e_zero; e.err = e_err;
      exp_q.push_back(e);
      name_q.push_back(nm);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
      @(posedge clk); #1;
      // Scramble the command bus: operands must already be latched.
      cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = 4'b0010; cmd_cin = ~cin;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         if (chk_cin0) chk({nm, ".alu_cin0"}, W'(alu_cin), W'(1'b0));
         if (chk_op0)  chk({nm, ".alu_op0"}, W'(alu_op), W'(4'b0000));
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, ".latency"}, W'(lat), W'(e_lat));
      if (hold > 0) begin
         snap_res   = rsp_result;
         snap_flags = {rsp_cout, rsp_zero, rsp_err};
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, W'(rsp_valid), W'(1'b1));
            chk({nm, ".hold_result"}, rsp_result, snap_res);
            chk({nm, ".hold_flags"}, W'({rsp_cout, rsp_zero, rsp_err}), W'(snap_flags));
            chk({nm, ".hold_cmd_ready"}, W'(cmd_ready), W'(1'b0));
         end
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({nm, ".valid_drop"}, W'(rsp_valid), W'(1'b0));
   endtask

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] f0s;
      logic [W-1:0] lo_ones;
      logic [W-1:0] two_lo_ones;
      int           seen;
      ones        = '1;
      f0s         = {(W/8){8'hF0}};
      lo_ones     = {{(W-64){1'b0}}, 64'hFFFF_FFFF_FFFF_FFFF};
      two_lo_ones = {{(W-128){1'b0}}, {128{1'b1}}};

      // Reset values while rst_n is held low with a command offered.
      cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = ones;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.cmd_ready", W'(cmd_ready), W'(1'b1));
      chk("reset.rsp_valid", W'(rsp_valid), W'(1'b0));
      chk("reset.rsp_result", rsp_result, '0);
      chk("reset.rsp_flags", W'({rsp_cout, rsp_zero, rsp_err}), W'(3'b000));
      chk("reset.alu_a", W'(alu_a), '0);
      chk("reset.alu_op", W'(alu_op), '0);
      chk("reset.alu_cin", W'(alu_cin), '0);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      //       name        op       a                 b            cin   exp result              cout  zero  err  lat hold cin0 op0
      run_cmd("add_chain", 4'b0010, lo_ones,          W'(1),       1'b0, W'(1) << 64,            1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);
      run_cmd("add_ovf",   4'b0010, ones,             W'(1),       1'b0, '0,                     1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);
      run_cmd("add_zero",  4'b0010, '0,               '0,          1'b0, '0,                     1'b0, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0);
      run_cmd("sub_chain", 4'b0110, W'(1) << 64,      W'(1),       1'b0, lo_ones,                1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);
      run_cmd("sub_undf",  4'b0110, '0,               W'(1),       1'b0, ones,                   1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);
      run_cmd("sub_bin",   4'b0110, W'(10),           W'(3),       1'b1, W'(6),                  1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);
      run_cmd("and_zero",  4'b0000, f0s,              ~f0s,        1'b1, '0,                     1'b0, 1'b1, 1'b0, 4, 0, 1'b1, 1'b0);
      run_cmd("nor_ones",  4'b1100, '0,               '0,          1'b1, ones,                   1'b0, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0);
      run_cmd("nand_zero", 4'b1101, ones,             ones,        1'b0, '0,                     1'b0, 1'b1, 1'b0, 4, 0, 1'b1, 1'b0);
      run_cmd("or_mix",    4'b0001, f0s,              W'(8'h0F),   1'b0, f0s | W'(8'h0F),        1'b0, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0);
      run_cmd("illegal",   4'b0011, ones,             ones,        1'b1, '0,                     1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 1'b1);
      run_cmd("bp_add",    4'b0010, W'(5),            W'(7),       1'b1, W'(13),                 1'b0, 1'b0, 1'b0, 4, 5, 1'b0, 1'b0);

      // Abort during RUN word 2: outputs reset at once, no response follows.
      wait_ready("abort");
      cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = {4{64'h1111}}; cmd_b = W'(1); cmd_cin = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("abort.alu_a_word2", W'(alu_a), W'(64'h1111));
      chk("abort.alu_op_run", W'(alu_op), W'(4'b0010));
      rst_n = 1'b0;
      #1;
      chk("abort.cmd_ready", W'(cmd_ready), W'(1'b1));
      chk("abort.rsp_valid", W'(rsp_valid), W'(1'b0));
      chk("abort.alu_a", W'(alu_a), '0);
      chk("abort.alu_op", W'(alu_op), '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("abort.no_rsp", W'(seen), '0);

      run_cmd("post_reset", 4'b0010, two_lo_ones, W'(1), 1'b1, (W'(1) << 128) | W'(1), 1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", W'(exp_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
